// File: rtl/axi_2_lint.sv
// AXI4 slave to LINT initiator bridge. One AXI transaction at a time, one
// 32-bit LINT request per beat, one LINT request outstanding at a time.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | arbitrate AR/AW, latch burst descriptor
// RD_REQ  | LINT read request driven, waiting for grant
// RD_WAIT | read granted, waiting for LINT response
// RD_RESP | R beat presented, waiting for r_ready_i
// WR_DATA | waiting for a W beat
// WR_REQ  | LINT write request driven, waiting for grant
// WR_WAIT | write granted, waiting for LINT response
// WR_RESP | B presented, waiting for b_ready_i
module axi_2_lint #(
   parameter int ADDR_WIDTH   = 32,
   parameter int AXI_ID_WIDTH = 5
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [AXI_ID_WIDTH-1:0] aw_id_i,
   input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
   input  logic [7:0]              aw_len_i,
   input  logic [1:0]              aw_burst_i,
   input  logic                    aw_valid_i,
   output logic                    aw_ready_o,
   input  logic [31:0]             w_data_i,
   input  logic [3:0]              w_strb_i,
   input  logic                    w_last_i,
   input  logic                    w_valid_i,
   output logic                    w_ready_o,
   output logic [AXI_ID_WIDTH-1:0] b_id_o,
   output logic [1:0]              b_resp_o,
   output logic                    b_valid_o,
   input  logic                    b_ready_i,
   input  logic [AXI_ID_WIDTH-1:0] ar_id_i,
   input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
   input  logic [7:0]              ar_len_i,
   input  logic [1:0]              ar_burst_i,
   input  logic                    ar_valid_i,
   output logic                    ar_ready_o,
   output logic [AXI_ID_WIDTH-1:0] r_id_o,
   output logic [31:0]             r_data_o,
   output logic [1:0]              r_resp_o,
   output logic                    r_last_o,
   output logic                    r_valid_o,
   input  logic                    r_ready_i,
   output logic                    data_req_o,
   output logic [ADDR_WIDTH-1:0]   data_addr_o,
   output logic                    data_we_o,
   output logic [31:0]             data_wdata_o,
   output logic [3:0]              data_be_o,
   input  logic                    data_gnt_i,
   input  logic                    data_rvalid_i,
   input  logic [31:0]             data_rdata_i,
   input  logic                    data_ropc_i
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD_REQ  = 3'd1;
   localparam logic [2:0] RD_WAIT = 3'd2;
   localparam logic [2:0] RD_RESP = 3'd3;
   localparam logic [2:0] WR_DATA = 3'd4;
   localparam logic [2:0] WR_REQ  = 3'd5;
   localparam logic [2:0] WR_WAIT = 3'd6;
   localparam logic [2:0] WR_RESP = 3'd7;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [2:0]              state;
   logic                    rr_q;
   logic [AXI_ID_WIDTH-1:0] id_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [7:0]              len_q;
   logic [1:0]              burst_q;
   logic [7:0]              beat_cnt;
   logic                    err_q;
   logic [31:0]             wdata_q;
   logic [3:0]              strb_q;
   logic [31:0]             rdata_q;
   logic [1:0]              rresp_q;
   logic [ADDR_WIDTH-1:0]   next_addr;
   logic                    last_beat;
   logic                    unused_w_last;

   // Beat count comes from len alone, so the W-channel last flag carries no information.
   assign unused_w_last = w_last_i;

   // FIXED keeps the address; INCR, WRAP and the reserved encoding all step by one word.
   assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + ADDR_WIDTH'(4);
   assign last_beat = (beat_cnt == len_q);

   // Round-robin between read and write when both address channels are valid.
   assign ar_ready_o = (state == IDLE) & ar_valid_i & (~aw_valid_i | ~rr_q);
   assign aw_ready_o = (state == IDLE) & aw_valid_i & (~ar_valid_i | rr_q);
   assign w_ready_o  = (state == WR_DATA);

   assign data_req_o   = (state == RD_REQ) | (state == WR_REQ);
   assign data_we_o    = (state == WR_REQ);
   assign data_addr_o  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign data_wdata_o = wdata_q;

   assign r_valid_o = (state == RD_RESP);
   assign r_last_o  = (state == RD_RESP) & last_beat;
   assign r_data_o  = rdata_q;
   assign r_resp_o  = rresp_q;
   assign r_id_o    = id_q;

   assign b_valid_o = (state == WR_RESP);
   assign b_resp_o  = err_q ? RESP_SLVERR : RESP_OKAY;
   assign b_id_o    = id_q;

   // Byte enables: full word on reads, latched strobe on writes, none otherwise.
   always_comb begin
      data_be_o = 4'h0;
      if (state == RD_REQ) begin
         data_be_o = 4'hF;
      end else if (state == WR_REQ) begin
         data_be_o = strb_q;
      end
   end

   // Burst sequencing: descriptor latch, per-beat LINT handshake, R/B return.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         rr_q     <= 1'b0;
         id_q     <= '0;
         addr_q   <= '0;
         len_q    <= '0;
         burst_q  <= '0;
         beat_cnt <= '0;
         err_q    <= 1'b0;
         wdata_q  <= '0;
         strb_q   <= '0;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         case (state)
            IDLE: begin
               if (ar_ready_o) begin
                  id_q     <= ar_id_i;
                  addr_q   <= ar_addr_i;
                  len_q    <= ar_len_i;
                  burst_q  <= ar_burst_i;
                  beat_cnt <= '0;
                  err_q    <= 1'b0;
                  rr_q     <= 1'b1;
                  state    <= RD_REQ;
               end else if (aw_ready_o) begin
                  id_q     <= aw_id_i;
                  addr_q   <= aw_addr_i;
                  len_q    <= aw_len_i;
                  burst_q  <= aw_burst_i;
                  beat_cnt <= '0;
                  err_q    <= 1'b0;
                  rr_q     <= 1'b0;
                  state    <= WR_DATA;
               end
            end
            RD_REQ: begin
               if (data_gnt_i) state <= RD_WAIT;
            end
            RD_WAIT: begin
               if (data_rvalid_i) begin
                  rdata_q <= data_rdata_i;
                  rresp_q <= data_ropc_i ? RESP_SLVERR : RESP_OKAY;
                  state   <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (r_ready_i) begin
                  if (last_beat) begin
                     state <= IDLE;
                  end else begin
                     addr_q   <= next_addr;
                     beat_cnt <= beat_cnt + 8'd1;
                     state    <= RD_REQ;
                  end
               end
            end
            WR_DATA: begin
               if (w_valid_i) begin
                  wdata_q <= w_data_i;
                  strb_q  <= w_strb_i;
                  state   <= WR_REQ;
               end
            end
            WR_REQ: begin
               if (data_gnt_i) state <= WR_WAIT;
            end
            WR_WAIT: begin
               if (data_rvalid_i) begin
                  err_q <= err_q | data_ropc_i;
                  if (last_beat) begin
                     state <= WR_RESP;
                  end else begin
                     addr_q   <= next_addr;
                     beat_cnt <= beat_cnt + 8'd1;
                     state    <= WR_DATA;
                  end
               end
            end
            WR_RESP: begin
               if (b_ready_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_2_lint.sv
// Scoreboard bench for axi_2_lint: AXI master tasks, a LINT slave model and
// monitors that pop expected LINT requests, R beats and B responses.
module tb_axi_2_lint;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } lint_t;

   typedef struct {
      logic [4:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } r_t;

   typedef struct {
      logic [4:0] id;
      logic [1:0] resp;
   } b_t;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [4:0]  aw_id_i = '0, ar_id_i = '0;
   logic [31:0] aw_addr_i = '0, ar_addr_i = '0;
   logic [7:0]  aw_len_i = '0, ar_len_i = '0;
   logic [1:0]  aw_burst_i = '0, ar_burst_i = '0;
   logic        aw_valid_i = 1'b0, ar_valid_i = 1'b0;
   logic        aw_ready_o, ar_ready_o;
   logic [31:0] w_data_i = '0;
   logic [3:0]  w_strb_i = '0;
   logic        w_last_i = 1'b0, w_valid_i = 1'b0, w_ready_o;
   logic [4:0]  b_id_o, r_id_o;
   logic [1:0]  b_resp_o, r_resp_o;
   logic        b_valid_o, b_ready_i = 1'b1;
   logic [31:0] r_data_o;
   logic        r_last_o, r_valid_o, r_ready_i = 1'b1;
   logic        data_req_o, data_we_o;
   logic [31:0] data_addr_o, data_wdata_o;
   logic [3:0]  data_be_o;
   logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_ropc_i = 1'b0;
   logic [31:0] data_rdata_i = '0;

   int n_cmp = 0;
   int n_err = 0;
   int r_seen = 0;
   int b_seen = 0;
   int resp_cnt = 0;
   int err_resp_idx = 0;
   bit slow_gnt = 1'b0;

   lint_t lint_q[$];
   r_t    r_q[$];
   b_t    b_q[$];

   axi_2_lint dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_burst_i(aw_burst_i),
      .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
      .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i),
      .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
      .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
      .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_burst_i(ar_burst_i),
      .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
      .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
      .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
      .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
      .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_gnt_i(data_gnt_i),
      .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_ropc_i(data_ropc_i)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h1000) return 32'hDEADBEEF;
      return {a[15:0], ~a[15:0]};
   endfunction

   // LINT slave: grant (optionally after one wait cycle), respond the cycle after grant.
   initial begin : lint_slave
      bit pend = 1'b0;
      bit held = 1'b0;
      logic [31:0] pend_addr = '0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            pend = 1'b0; held = 1'b0;
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_ropc_i = 1'b0;
         end else begin
            if (pend) begin
               resp_cnt = resp_cnt + 1;
               data_rvalid_i = 1'b1;
               data_rdata_i = mem(pend_addr);
               data_ropc_i = (resp_cnt == err_resp_idx);
            end else begin
               data_rvalid_i = 1'b0;
               data_ropc_i = 1'b0;
            end
            if (data_req_o && slow_gnt && !held) begin
               data_gnt_i = 1'b0; held = 1'b1; pend = 1'b0;
            end else begin
               data_gnt_i = data_req_o; pend = data_req_o; held = 1'b0;
               pend_addr = data_addr_o;
            end
         end
      end
   end

   // Scoreboard monitors: sample mid-cycle, a handshake seen here completes at the next posedge.
   initial begin : monitors
      lint_t le;
      r_t    re;
      b_t    be;
      forever begin
         @(negedge clk_i); #2;
         if (rst_ni) begin
            if (data_req_o && data_gnt_i) begin
               n_cmp++;
               if (lint_q.size() == 0) begin
                  n_err++;
                  $display("FAIL lint_unexpected addr=%h we=%b", data_addr_o, data_we_o);
               end else begin
                  le = lint_q.pop_front();
                  if (data_addr_o !== le.addr || data_we_o !== le.we || data_be_o !== le.be ||
                      (le.we && data_wdata_o !== le.wdata)) begin
                     n_err++;
                     $display("FAIL lint_req got addr=%h we=%b be=%h wd=%h exp addr=%h we=%b be=%h wd=%h",
                              data_addr_o, data_we_o, data_be_o, data_wdata_o, le.addr, le.we, le.be, le.wdata);
                  end
               end
            end
            if (r_valid_o && r_ready_i) begin
               n_cmp++;
               r_seen++;
               if (r_q.size() == 0) begin
                  n_err++;
                  $display("FAIL r_unexpected data=%h", r_data_o);
               end else begin
                  re = r_q.pop_front();
                  if (r_id_o !== re.id || r_data_o !== re.data || r_resp_o !== re.resp || r_last_o !== re.last) begin
                     n_err++;
                     $display("FAIL r_beat got id=%h data=%h resp=%b last=%b exp id=%h data=%h resp=%b last=%b",
                              r_id_o, r_data_o, r_resp_o, r_last_o, re.id, re.data, re.resp, re.last);
                  end
               end
            end
            if (b_valid_o && b_ready_i) begin
               n_cmp++;
               b_seen++;
               if (b_q.size() == 0) begin
                  n_err++;
                  $display("FAIL b_unexpected id=%h resp=%b", b_id_o, b_resp_o);
               end else begin
                  be = b_q.pop_front();
                  if (b_id_o !== be.id || b_resp_o !== be.resp) begin
                     n_err++;
                     $display("FAIL b_resp got id=%h resp=%b exp id=%h resp=%b", b_id_o, b_resp_o, be.id, be.resp);
                  end
               end
            end
         end
      end
   end

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic apply_reset();
      @(negedge clk_i);
      rst_ni = 1'b0;
      ar_valid_i = 1'b0; aw_valid_i = 1'b0; w_valid_i = 1'b0;
      r_ready_i = 1'b1; b_ready_i = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic send_ar(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      @(negedge clk_i);
      ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_burst_i = burst; ar_valid_i = 1'b1;
      #2;
      while (!ar_ready_o && n < 200) begin @(negedge clk_i); #2; n++; end
      if (n >= 200) begin n_cmp++; n_err++; $display("FAIL ar_timeout got ready=0 need ready=1"); end
      @(negedge clk_i);
      ar_valid_i = 1'b0;
   endtask

   task automatic send_aw(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      @(negedge clk_i);
      aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_burst_i = burst; aw_valid_i = 1'b1;
      #2;
      while (!aw_ready_o && n < 200) begin @(negedge clk_i); #2; n++; end
      if (n >= 200) begin n_cmp++; n_err++; $display("FAIL aw_timeout got ready=0 need ready=1"); end
      @(negedge clk_i);
      aw_valid_i = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
      int n = 0;
      @(negedge clk_i);
      w_data_i = data; w_strb_i = strb; w_last_i = last; w_valid_i = 1'b1;
      #2;
      while (!w_ready_o && n < 200) begin @(negedge clk_i); #2; n++; end
      if (n >= 200) begin n_cmp++; n_err++; $display("FAIL w_timeout got ready=0 need ready=1"); end
      @(negedge clk_i);
      w_valid_i = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((lint_q.size() != 0 || r_q.size() != 0 || b_q.size() != 0) && n < 300) begin
         @(negedge clk_i); n++;
      end
      repeat (2) @(negedge clk_i);
      if (n >= 300) begin
         n_cmp++; n_err++;
         $display("FAIL drain_timeout left lint=%0d r=%0d b=%0d need 0", lint_q.size(), r_q.size(), b_q.size());
         lint_q.delete(); r_q.delete(); b_q.delete();
      end
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if ({ar_ready_o, aw_ready_o, w_ready_o, b_valid_o, r_valid_o, data_req_o} !== 6'b0) begin
         n_err++; $display("FAIL reset_handshake got %b need 000000",
                           {ar_ready_o, aw_ready_o, w_ready_o, b_valid_o, r_valid_o, data_req_o});
      end
      n_cmp++;
      if (r_data_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h need 0", r_data_o); end
      n_cmp++;
      if ({r_id_o, b_id_o} !== 10'h0) begin n_err++; $display("FAIL reset_ids got %h/%h need 0", r_id_o, b_id_o); end
      n_cmp++;
      if ({r_resp_o, b_resp_o} !== 4'h0) begin n_err++; $display("FAIL reset_resp got %b/%b need 0", r_resp_o, b_resp_o); end
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   task automatic test_single_read();
      lint_q.push_back('{32'h1000, 1'b0, 4'hF, 32'h0});
      r_q.push_back('{5'h03, 32'hDEADBEEF, 2'b00, 1'b1});
      send_ar(5'h03, 32'h1000, 8'd0, 2'b01);
      #2;
      n_cmp++;
      if (data_req_o !== 1'b1 || r_valid_o !== 1'b0) begin
         n_err++; $display("FAIL lat_cycle1 got req=%b rvalid=%b need req=1 rvalid=0", data_req_o, r_valid_o);
      end
      @(negedge clk_i); #2;
      n_cmp++;
      if (r_valid_o !== 1'b0) begin n_err++; $display("FAIL lat_cycle2 got rvalid=%b need 0", r_valid_o); end
      @(negedge clk_i); #2;
      n_cmp++;
      if (r_valid_o !== 1'b1) begin n_err++; $display("FAIL lat_cycle3 got rvalid=%b need 1", r_valid_o); end
      wait_idle();
   endtask

   task automatic test_incr_read_stall();
      int r0, stall, n;
      slow_gnt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         lint_q.push_back('{32'h2004 + 32'(4 * i), 1'b0, 4'hF, 32'h0});
         r_q.push_back('{5'h07, mem(32'h2004 + 32'(4 * i)), 2'b00, (i == 3)});
      end
      send_ar(5'h07, 32'h2004, 8'd3, 2'b01);
      r0 = r_seen; stall = 0; n = 0;
      while (r_seen - r0 < 4 && n < 300) begin
         if (r_valid_o && (r_seen - r0) == 1 && stall < 2) begin
            r_ready_i = 1'b0; stall++;
         end else begin
            r_ready_i = 1'b1;
         end
         #2;
         if (!r_ready_i) begin
            n_cmp++;
            if (r_data_o !== mem(32'h2008) || r_last_o !== 1'b0 || r_id_o !== 5'h07 || r_resp_o !== 2'b00) begin
               n_err++; $display("FAIL stall_payload got data=%h last=%b id=%h need data=%h last=0 id=07",
                                 r_data_o, r_last_o, r_id_o, mem(32'h2008));
            end
         end
         @(negedge clk_i); n++;
      end
      r_ready_i = 1'b1;
      n_cmp++;
      if (stall != 2 || n >= 300) begin
         n_err++; $display("FAIL stall_run got stalls=%0d beats=%0d need stalls=2 beats=4", stall, r_seen - r0);
      end
      slow_gnt = 1'b0;
      wait_idle();
   endtask

   task automatic test_write_err();
      logic [31:0] wd[3];
      logic [3:0]  sb[3];
      int b0;
      wd = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003};
      sb = '{4'hF, 4'h3, 4'hC};
      err_resp_idx = resp_cnt + 2;
      for (int i = 0; i < 3; i++) lint_q.push_back('{32'h4000 + 32'(4 * i), 1'b1, sb[i], wd[i]});
      b_q.push_back('{5'h09, 2'b10});
      b0 = b_seen;
      send_aw(5'h09, 32'h4000, 8'd2, 2'b01);
      for (int i = 0; i < 3; i++) send_w(wd[i], sb[i], (i == 2));
      wait_idle();
      repeat (3) @(negedge clk_i);
      n_cmp++;
      if (b_seen - b0 != 1) begin n_err++; $display("FAIL b_count got %0d need 1", b_seen - b0); end
      err_resp_idx = 0;
   endtask

   task automatic test_fixed_write();
      for (int i = 0; i < 4; i++) lint_q.push_back('{32'h3000, 1'b1, 4'hF, 32'h1111_0000 + 32'(i)});
      b_q.push_back('{5'h02, 2'b00});
      send_aw(5'h02, 32'h3000, 8'd3, 2'b00);
      for (int i = 0; i < 4; i++) send_w(32'h1111_0000 + 32'(i), 4'hF, (i == 3));
      wait_idle();
   endtask

   task automatic test_arbitration();
      int n;
      apply_reset();
      lint_q.push_back('{32'h5000, 1'b0, 4'hF, 32'h0});
      lint_q.push_back('{32'h5100, 1'b1, 4'hF, 32'h0000_00A0});
      r_q.push_back('{5'h01, mem(32'h5000), 2'b00, 1'b1});
      b_q.push_back('{5'h02, 2'b00});
      @(negedge clk_i);
      ar_id_i = 5'h01; ar_addr_i = 32'h5000; ar_len_i = 8'd0; ar_burst_i = 2'b01; ar_valid_i = 1'b1;
      aw_id_i = 5'h02; aw_addr_i = 32'h5100; aw_len_i = 8'd0; aw_burst_i = 2'b01; aw_valid_i = 1'b1;
      #2;
      n_cmp++;
      if (ar_ready_o !== 1'b1 || aw_ready_o !== 1'b0) begin
         n_err++; $display("FAIL arb_first got ar=%b aw=%b need ar=1 aw=0", ar_ready_o, aw_ready_o);
      end
      @(negedge clk_i);
      ar_valid_i = 1'b0;
      n = 0; #2;
      while (!aw_ready_o && n < 100) begin @(negedge clk_i); #2; n++; end
      n_cmp++;
      if (n >= 100) begin n_err++; $display("FAIL arb_write_after got aw_ready=0 need 1"); end
      @(negedge clk_i);
      aw_valid_i = 1'b0;
      send_w(32'h0000_00A0, 4'hF, 1'b1);
      wait_idle();

      lint_q.push_back('{32'h5200, 1'b0, 4'hF, 32'h0});
      lint_q.push_back('{32'h5300, 1'b1, 4'hF, 32'h0000_00B0});
      lint_q.push_back('{32'h5400, 1'b0, 4'hF, 32'h0});
      r_q.push_back('{5'h03, mem(32'h5200), 2'b00, 1'b1});
      r_q.push_back('{5'h05, mem(32'h5400), 2'b00, 1'b1});
      b_q.push_back('{5'h04, 2'b00});
      @(negedge clk_i);
      ar_id_i = 5'h03; ar_addr_i = 32'h5200; ar_valid_i = 1'b1;
      aw_id_i = 5'h04; aw_addr_i = 32'h5300; aw_valid_i = 1'b1;
      #2;
      n_cmp++;
      if (ar_ready_o !== 1'b1 || aw_ready_o !== 1'b0) begin
         n_err++; $display("FAIL arb_second got ar=%b aw=%b need ar=1 aw=0", ar_ready_o, aw_ready_o);
      end
      @(negedge clk_i);
      ar_id_i = 5'h05; ar_addr_i = 32'h5400;
      n = 0; #2;
      while (!(ar_ready_o || aw_ready_o) && n < 100) begin @(negedge clk_i); #2; n++; end
      n_cmp++;
      if (ar_ready_o !== 1'b0 || aw_ready_o !== 1'b1) begin
         n_err++; $display("FAIL arb_rr_write got ar=%b aw=%b need ar=0 aw=1", ar_ready_o, aw_ready_o);
      end
      @(negedge clk_i);
      aw_valid_i = 1'b0;
      send_w(32'h0000_00B0, 4'hF, 1'b1);
      n = 0; #2;
      while (!ar_ready_o && n < 100) begin @(negedge clk_i); #2; n++; end
      if (n >= 100) begin n_cmp++; n_err++; $display("FAIL arb_third_read got ar_ready=0 need 1"); end
      @(negedge clk_i);
      ar_valid_i = 1'b0;
      wait_idle();
   endtask

   task automatic test_reset_midburst();
      lint_q.push_back('{32'h6000, 1'b0, 4'hF, 32'h0});
      send_ar(5'h06, 32'h6000, 8'd3, 2'b01);
      @(negedge clk_i);
      rst_ni = 1'b0;
      #2;
      n_cmp++;
      if (r_valid_o !== 1'b0 || data_req_o !== 1'b0 || ar_ready_o !== 1'b0) begin
         n_err++; $display("FAIL midreset_outputs got rvalid=%b req=%b ar_ready=%b need 0/0/0",
                           r_valid_o, data_req_o, ar_ready_o);
      end
      n_cmp++;
      if (lint_q.size() != 0) begin
         n_err++; $display("FAIL midreset_first_req got pending=%0d need 0", lint_q.size());
         lint_q.delete();
      end
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      lint_q.push_back('{32'h7000, 1'b0, 4'hF, 32'h0});
      r_q.push_back('{5'h08, mem(32'h7000), 2'b00, 1'b1});
      send_ar(5'h08, 32'h7000, 8'd0, 2'b01);
      wait_idle();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_incr_read_stall();
      test_write_err();
      test_fixed_write();
      test_arbitration();
      test_reset_midburst();
      repeat (5) @(negedge clk_i);
      n_cmp++;
      if (lint_q.size() != 0 || r_q.size() != 0 || b_q.size() != 0) begin
         n_err++; $display("FAIL final_drain got lint=%0d r=%0d b=%0d need 0", lint_q.size(), r_q.size(), b_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_2_lint.md
Name: axi_2_lint

Overview:
- AXI4 slave-to-LINT initiator bridge; the reverse direction of the LINT-to-AXI master bridge.
- Accepts single-ID AXI4 read and write bursts from the SoC AXI fabric.
- Issues one 32-bit LINT request per beat toward the L2/TCDM interconnect.
- Returns R beats and a single B response. One AXI transaction is in flight at a time; one LINT request is outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, AXI and LINT address width.
- AXI_ID_WIDTH, 5, AXI ID width; the ID is echoed on R/B.
- Data width is fixed at 32 bits and is not a parameter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- aw_id_i, aw_addr_i, aw_len_i, aw_burst_i  in  AXI_ID_WIDTH/ADDR_WIDTH/8/2  write address channel
- aw_valid_i in 1 / aw_ready_o out 1  write address handshake
- w_data_i, w_strb_i, w_last_i  in  32/4/1  write data channel
- w_valid_i in 1 / w_ready_o out 1  write data handshake
- b_id_o, b_resp_o  out  AXI_ID_WIDTH/2  write response
- b_valid_o out 1 / b_ready_i in 1  write response handshake
- ar_id_i, ar_addr_i, ar_len_i, ar_burst_i  in  AXI_ID_WIDTH/ADDR_WIDTH/8/2  read address channel
- ar_valid_i in 1 / ar_ready_o out 1  read address handshake
- r_id_o, r_data_o, r_resp_o, r_last_o  out  AXI_ID_WIDTH/32/2/1  read data channel
- r_valid_o out 1 / r_ready_i in 1  read data handshake
- data_req_o out 1, data_addr_o out ADDR_WIDTH, data_we_o out 1, data_wdata_o out 32, data_be_o out 4  LINT request
- data_gnt_i  in  1  LINT grant
- data_rvalid_i in 1, data_rdata_i in 32, data_ropc_i in 1  LINT response; ropc=1 means error

Behaviour:
Reset:
- All valid, ready and req outputs are 0.
- r_data_o, r_id_o, b_id_o, r_resp_o and b_resp_o are 0.
- State is IDLE; rr_q=0 (read has priority first).

FSM states: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_WAIT, WR_RESP.

IDLE:
- ar_ready_o = ar_valid_i & (~aw_valid_i | ~rr_q).
- aw_ready_o = aw_valid_i & (~ar_valid_i | rr_q).
- Exactly one channel is accepted per cycle.
- On acceptance, latch id, addr, len and burst; clear beat_cnt and err_q.
- Accepting a read sets rr_q=1 and goes to RD_REQ. Accepting a write clears rr_q and goes to WR_DATA.

RD_REQ:
- data_req_o=1, data_we_o=0, data_be_o=4'hF, data_addr_o = {cur_addr[ADDR_WIDTH-1:2],2'b00}.
- On data_gnt_i go to RD_WAIT. The request is held stable until granted.

RD_WAIT:
- On data_rvalid_i, register r_data_o=data_rdata_i and r_resp_o = ropc ? SLVERR(2'b10) : OKAY(2'b00).
- Go to RD_RESP.

RD_RESP:
- r_valid_o=1, r_last_o=(beat_cnt==len).
- On r_ready_i: if last, go to IDLE. Otherwise advance the address, increment beat_cnt and go to RD_REQ.
- The R payload is stable while r_ready_i is low.

WR_DATA:
- w_ready_o=1. On w_valid_i, latch data and strb, then go to WR_REQ.

WR_REQ:
- data_req_o=1, data_we_o=1, data_be_o=latched strb, data_wdata_o=latched data.
- On data_gnt_i go to WR_WAIT.

WR_WAIT:
- On data_rvalid_i, set err_q |= data_ropc_i.
- If beat_cnt==len, go to WR_RESP. Otherwise advance the address, increment beat_cnt and go to WR_DATA.

WR_RESP:
- b_valid_o=1, b_resp_o = err_q ? SLVERR : OKAY, b_id_o=latched id.
- On b_ready_i go to IDLE.

Address advance:
- FIXED (2'b00): unchanged.
- INCR (2'b01) and WRAP (2'b10): +4, modulo 2^ADDR_WIDTH. WRAP is handled as INCR.
- Reserved (2'b11) is treated as INCR.
- The AXI size field is not a port; every beat is 32-bit.

Other rules:
- Beat count is taken from len; w_last_i is ignored.
- data_rvalid_i outside RD_WAIT/WR_WAIT is ignored.
- A LINT response never arrives in the grant cycle.
- Minimum single-beat read latency: AR handshake at cycle 0, req at 1 (gnt at 1), rvalid at 2, r_valid_o at 3.
- Reset mid-burst aborts the transaction immediately. No B/R is produced for it, and all outputs return to their reset values.

Test Plan:
- Single read: AR addr=0x1000, len=0; LINT gnt immediate, rdata=0xDEADBEEF at +1 -> R data=0xDEADBEEF, resp=OKAY, last=1, id echoed, r_valid_o at cycle 3.
- 4-beat INCR read at 0x2004 with r_ready_i low for 2 cycles on beat 1 -> LINT addrs 0x2004/0x2008/0x200C/0x2010; R payload held stable during stall; last only on beat 3.
- 3-beat INCR write, strb 0xF/0x3/0xC, ropc=1 on beat 1 only -> be sequence matches strb; exactly one B with resp=SLVERR.
- AR and AW valid in the same IDLE cycle after reset -> read accepted first, then write; next simultaneous pair -> read accepted first again, because rr_q toggles back.
- FIXED write, len=3, addr=0x3000 -> four LINT writes all at 0x3000; B resp=OKAY.
- Reset asserted in RD_WAIT of a 4-beat read -> r_valid_o, data_req_o and ar_ready_o are 0; the next AR is served from IDLE.
